ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the RV64I+Zba five-stage pipeline. It consumes the decode/execute register outputs, resolves operand forwarding, computes the ALU result (base, word and Zba ops), resolves branches and jumps, and registers results into the execute/memory pipeline register. Redirect signals to fetch are combinational; everything sent to the memory stage is registered.

## Interface
- No parameters; datapath fixed at 64 bits.
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- RD1_E, RD2_E  in  64  register operands from the decode/execute register
- PC_E, ImmExt_E  in  64  instruction PC, extended immediate
- Rd_E  in  5  destination register
- RegWrite_E, MemWrite_E, ALUSrc_E, Branch_E, Jump_E  in  1  control from the decode/execute register
- ResultSrc_E  in  2  writeback select, passed through
- ALUControl_E  in  4  ALU opcode (encoding below)
- Funct3_E  in  3  branch condition
- Word_E  in  1  RV64 W-form operation
- Jalr_E  in  1  jump target is register-relative
- ForwardA_E, ForwardB_E  in  2  forward select: 00 register file, 01 Result_W, 10 ALUResult_M, 11 reserved (treated as 00)
- Result_W  in  64  writeback-stage result
- StallM  in  1  hold the execute/memory register
- FlushM  in  1  insert a bubble into the execute/memory register
- PCSrc_E  out  1  redirect fetch (combinational)
- PCTarget_E  out  64  redirect address (combinational)
- ALUResult_M, WriteData_M, PCPlus4_M  out  64  registered results
- Rd_M  out  5; RegWrite_M, MemWrite_M  out  1; ResultSrc_M  out  2  registered control

## Operation
- SrcA = forward mux A on RD1_E. FwdB = forward mux B on RD2_E. SrcB = ALUSrc_E ? ImmExt_E : FwdB.
- ALUControl: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 SH1ADD (B+(A<<1)), 11 SH2ADD, 12 SH3ADD, 13 ADD.UW (B+zext(A[31:0])), 14 SLLI.UW (zext(A[31:0])<<B[5:0]), 15 PASS_B (LUI).
- 64-bit shifts use SrcB[5:0]. SLT and SLTU return 0 or 1 in bit 0.
- Word_E=1, valid only with ADD, SUB, SLL, SRL and SRA: operate on the low 32 bits, shift amount SrcB[4:0], SRL/SRA read A[31:0], result sign-extended from bit 31. Word_E with any other opcode: result is the non-word result. Not an error.
- All add, subtract and shift-add arithmetic wraps modulo 2^64 (word forms modulo 2^32). No overflow flag.
- Branch conditions use SrcA and FwdB; the ALU result is not reused. Funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. Encodings 010 and 011 are never taken.
- PCSrc_E = Jump_E | (Branch_E & condition true).
- PCTarget_E = Jalr_E ? ((SrcA + ImmExt_E) & ~64'h1) : (PC_E + ImmExt_E).
- PCPlus4 = PC_E + 4, registered for JAL/JALR writeback.
- WriteData_M captures FwdB, the forwarded value, not the immediate.

## Timing
- Execute/memory register update priority: rst > FlushM > StallM > load.
- rst=1 at an edge: every registered output goes to 0.
- FlushM=1: RegWrite_M and MemWrite_M go to 0, ResultSrc_M goes to 0, Rd_M goes to 0. Data outputs may load or clear; the bench checks only control outputs.
- StallM=1 with FlushM=0: all registered outputs hold.
- Otherwise: all registered outputs capture the execute-stage values.
- Latency: one cycle from execute inputs to *_M outputs. PCSrc_E and PCTarget_E have zero latency in the same cycle.
- The hazard unit must not drive ForwardA/B=10 while the memory stage holds a bubble. The block does not check for this.
- FlushM and StallM asserted together: the flush wins.
- Reset mid-stall: the register clears on that edge and resumes loading once rst and StallM are both low.

## Test plan
- ADD and SUB wrap: A=64'hFFFF_FFFF_FFFF_FFFF, B=1, ADD -> ALUResult_M=0 one cycle later. A=0, B=1, SUB -> 64'hFFFF_FFFF_FFFF_FFFF.
- Zba: A=64'hFFFF_FFFF_0000_0003, B=10. SH3ADD -> 64'hFFFF_FFF8_0000_0022. ADD.UW -> 13. SLLI.UW with B=4 -> 64'h30.
- Word form: ADD with Word_E=1, A=32'h7FFF_FFFF, B=1 -> 64'hFFFF_FFFF_8000_0000. SRA with Word_E=1, A=64'h0000_0000_8000_0000, B=4 -> 64'hFFFF_FFFF_F800_0000.
- Forwarding and branch: RD1_E=0, ForwardA=10 with ALUResult_M=5, RD2_E=5, Branch_E=1, Funct3=000 -> PCSrc_E=1 and PCTarget_E=PC_E+ImmExt_E in the same cycle. With Funct3=001 -> PCSrc_E=0.
- JALR: SrcA=64'h1001, Imm=2, Jump_E=1, Jalr_E=1 -> PCTarget_E=64'h1002, PCSrc_E=1, PCPlus4_M=PC_E+4.
- Register control: load RegWrite_E=1, Rd_E=7. Then StallM=1 for 2 cycles with changed inputs -> outputs hold. Then FlushM=1 together with StallM=1 -> RegWrite_M=0, Rd_M=0. Then rst=1 -> all outputs 0.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of the RV64I+Zba pipeline: operand forwarding, ALU (base, word and Zba ops),
// branch/jump resolution and the execute/memory pipeline register.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] RD1_E,
    input  logic [63:0] RD2_E,
    input  logic [63:0] PC_E,
    input  logic [63:0] ImmExt_E,
    input  logic [4:0]  Rd_E,
    input  logic        RegWrite_E,
    input  logic        MemWrite_E,
    input  logic        ALUSrc_E,
    input  logic        Branch_E,
    input  logic        Jump_E,
    input  logic [1:0]  ResultSrc_E,
    input  logic [3:0]  ALUControl_E,
    input  logic [2:0]  Funct3_E,
    input  logic        Word_E,
    input  logic        Jalr_E,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    input  logic [63:0] Result_W,
    input  logic        StallM,
    input  logic        FlushM,
    output logic        PCSrc_E,
    output logic [63:0] PCTarget_E,
    output logic [63:0] ALUResult_M,
    output logic [63:0] WriteData_M,
    output logic [63:0] PCPlus4_M,
    output logic [4:0]  Rd_M,
    output logic        RegWrite_M,
    output logic        MemWrite_M,
    output logic [1:0]  ResultSrc_M
);

    logic [63:0] src_a;
    logic [63:0] fwd_b;
    logic [63:0] src_b;
    logic [63:0] alu_res;
    logic [63:0] alu_out;
    logic [63:0] a_uw;
    logic [63:0] pc_plus4;
    logic [31:0] word_res;
    logic        word_valid;
    logic [5:0]  shamt;
    logic [4:0]  shamt_w;
    logic        cond_eq;
    logic        cond_lt;
    logic        cond_ltu;
    logic        taken;

    // Forward select 11 is reserved and behaves like the register file path.
    always_comb begin
        case (ForwardA_E)
            2'b01:   src_a = Result_W;
            2'b10:   src_a = ALUResult_M;
            default: src_a = RD1_E;
        endcase
        case (ForwardB_E)
            2'b01:   fwd_b = Result_W;
            2'b10:   fwd_b = ALUResult_M;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_b   = ALUSrc_E ? ImmExt_E : fwd_b;
    assign shamt   = src_b[5:0];
    assign shamt_w = src_b[4:0];
    assign a_uw    = {32'h0, src_a[31:0]};

    always_comb begin
        alu_res = '0;
        case (ALUControl_E)
            4'd0:    alu_res = src_a + src_b;
            4'd1:    alu_res = src_a - src_b;
            4'd2:    alu_res = src_a & src_b;
            4'd3:    alu_res = src_a | src_b;
            4'd4:    alu_res = src_a ^ src_b;
            4'd5:    alu_res = {63'h0, $signed(src_a) < $signed(src_b)};
            4'd6:    alu_res = {63'h0, src_a < src_b};
            4'd7:    alu_res = src_a << shamt;
            4'd8:    alu_res = src_a >> shamt;
            4'd9:    alu_res = $unsigned($signed(src_a) >>> shamt);
            4'd10:   alu_res = src_b + {src_a[62:0], 1'b0};
            4'd11:   alu_res = src_b + {src_a[61:0], 2'b0};
            4'd12:   alu_res = src_b + {src_a[60:0], 3'b0};
            4'd13:   alu_res = src_b + a_uw;
            4'd14:   alu_res = a_uw << shamt;
            default: alu_res = src_b;
        endcase
    end

    // W-forms exist only for ADD/SUB/SLL/SRL/SRA; other opcodes ignore Word_E.
    always_comb begin
        word_res   = '0;
        word_valid = 1'b1;
        case (ALUControl_E)
            4'd0:    word_res = src_a[31:0] + src_b[31:0];
            4'd1:    word_res = src_a[31:0] - src_b[31:0];
            4'd7:    word_res = src_a[31:0] << shamt_w;
            4'd8:    word_res = src_a[31:0] >> shamt_w;
            4'd9:    word_res = $unsigned($signed(src_a[31:0]) >>> shamt_w);
            default: word_valid = 1'b0;
        endcase
        alu_out = (Word_E && word_valid) ? {{32{word_res[31]}}, word_res} : alu_res;
    end

    // Branch compare uses the forwarded rs2 value, never the immediate.
    assign cond_eq  = (src_a == fwd_b);
    assign cond_lt  = ($signed(src_a) < $signed(fwd_b));
    assign cond_ltu = (src_a < fwd_b);

    always_comb begin
        case (Funct3_E)
            3'b000:  taken = cond_eq;
            3'b001:  taken = !cond_eq;
            3'b100:  taken = cond_lt;
            3'b101:  taken = !cond_lt;
            3'b110:  taken = cond_ltu;
            3'b111:  taken = !cond_ltu;
            default: taken = 1'b0;
        endcase
    end

    assign PCSrc_E    = Jump_E | (Branch_E & taken);
    assign PCTarget_E = Jalr_E ? ((src_a + ImmExt_E) & ~64'h1) : (PC_E + ImmExt_E);
    assign pc_plus4   = PC_E + 64'd4;

    // Flush clears only control; data still loads since a bubble never commits it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ALUResult_M <= '0;
            WriteData_M <= '0;
            PCPlus4_M   <= '0;
            Rd_M        <= '0;
            RegWrite_M  <= 1'b0;
            MemWrite_M  <= 1'b0;
            ResultSrc_M <= '0;
        end else if (FlushM) begin
            ALUResult_M <= alu_out;
            WriteData_M <= fwd_b;
            PCPlus4_M   <= pc_plus4;
            Rd_M        <= '0;
            RegWrite_M  <= 1'b0;
            MemWrite_M  <= 1'b0;
            ResultSrc_M <= '0;
        end else if (!StallM) begin
            ALUResult_M <= alu_out;
            WriteData_M <= fwd_b;
            PCPlus4_M   <= pc_plus4;
            Rd_M        <= Rd_E;
            RegWrite_M  <= RegWrite_E;
            MemWrite_M  <= MemWrite_E;
            ResultSrc_M <= ResultSrc_E;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: randomized operations against an arithmetic reference model, then
// directed checks of the documented corner cases and pipeline register control.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] RD1_E, RD2_E, PC_E, ImmExt_E, Result_W;
    logic [4:0]  Rd_E;
    logic        RegWrite_E, MemWrite_E, ALUSrc_E, Branch_E, Jump_E, Word_E, Jalr_E;
    logic [1:0]  ResultSrc_E, ForwardA_E, ForwardB_E;
    logic [3:0]  ALUControl_E;
    logic [2:0]  Funct3_E;
    logic        StallM, FlushM;
    logic        PCSrc_E;
    logic [63:0] PCTarget_E, ALUResult_M, WriteData_M, PCPlus4_M;
    logic [4:0]  Rd_M;
    logic        RegWrite_M, MemWrite_M;
    logic [1:0]  ResultSrc_M;

    int tests = 0;
    int fails = 0;

    ex_stage dut (
        .clk(clk), .rst(rst), .RD1_E(RD1_E), .RD2_E(RD2_E), .PC_E(PC_E), .ImmExt_E(ImmExt_E),
        .Rd_E(Rd_E), .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E), .ALUSrc_E(ALUSrc_E),
        .Branch_E(Branch_E), .Jump_E(Jump_E), .ResultSrc_E(ResultSrc_E),
        .ALUControl_E(ALUControl_E), .Funct3_E(Funct3_E), .Word_E(Word_E), .Jalr_E(Jalr_E),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .Result_W(Result_W),
        .StallM(StallM), .FlushM(FlushM), .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E),
        .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M), .PCPlus4_M(PCPlus4_M),
        .Rd_M(Rd_M), .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M),
        .ResultSrc_M(ResultSrc_M)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sext32(input logic [63:0] x);
        logic [63:0] hi;
        hi = x[31] ? 64'hFFFF_FFFF_0000_0000 : 64'h0;
        return hi | (x & 64'hFFFF_FFFF);
    endfunction

    // Shifts modelled as multiply/divide by a power of two.
    function automatic logic [63:0] sra_ref(input logic [63:0] a, input int sh);
        logic [63:0] p;
        p = 64'd1 << sh;
        return a[63] ? ~((~a) / p) : a / p;
    endfunction

    function automatic logic [63:0] alu_ref(input logic [63:0] a, input logic [63:0] b,
                                            input int op, input logic word);
        logic [63:0] lo_a;
        int sh;
        int shw;
        sh   = int'(b % 64);
        shw  = int'(b % 32);
        lo_a = a & 64'hFFFF_FFFF;
        if (word && (op == 0 || op == 1 || op == 7 || op == 8 || op == 9)) begin
            case (op)
                0:       return sext32(a + b);
                1:       return sext32(a - b);
                7:       return sext32(a * (64'd1 << shw));
                8:       return sext32(lo_a / (64'd1 << shw));
                default: return sext32(sra_ref(sext32(a), shw));
            endcase
        end
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            6:  return (a < b) ? 64'd1 : 64'd0;
            7:  return a * (64'd1 << sh);
            8:  return a / (64'd1 << sh);
            9:  return sra_ref(a, sh);
            10: return b + a * 2;
            11: return b + a * 4;
            12: return b + a * 8;
            13: return b + lo_a;
            14: return lo_a * (64'd1 << sh);
            default: return b;
        endcase
    endfunction

    function automatic logic taken_ref(input logic [63:0] a, input logic [63:0] b, input int f3);
        case (f3)
            0:       return a == b;
            1:       return a != b;
            4:       return $signed(a) < $signed(b);
            5:       return $signed(a) >= $signed(b);
            6:       return a < b;
            7:       return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] rnd64();
        if ($urandom_range(0, 3) == 0) return 64'($urandom_range(0, 40));
        return {$urandom, $urandom};
    endfunction

    task automatic idle_inputs();
        RD1_E = '0; RD2_E = '0; PC_E = '0; ImmExt_E = '0; Result_W = '0; Rd_E = '0;
        RegWrite_E = 0; MemWrite_E = 0; ALUSrc_E = 0; Branch_E = 0; Jump_E = 0;
        Word_E = 0; Jalr_E = 0; ResultSrc_E = '0; ForwardA_E = '0; ForwardB_E = '0;
        ALUControl_E = '0; Funct3_E = '0; StallM = 0; FlushM = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] op, input logic word, input logic [63:0] exp);
        RD1_E = a; RD2_E = b; ALUControl_E = op; Word_E = word;
        ALUSrc_E = 0; ForwardA_E = 0; ForwardB_E = 0;
        step();
        check(tag, ALUResult_M, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alu"}, ALUResult_M, 64'h0);
        check({tag, "_wd"}, WriteData_M, 64'h0);
        check({tag, "_pc4"}, PCPlus4_M, 64'h0);
        check({tag, "_rd"}, 64'(Rd_M), 64'h0);
        check({tag, "_rw"}, 64'(RegWrite_M), 64'h0);
        check({tag, "_mw"}, 64'(MemWrite_M), 64'h0);
        check({tag, "_rs"}, 64'(ResultSrc_M), 64'h0);
    endtask

    initial begin
        logic [63:0] exp_alu_m, a, fb, b, exp_tgt;
        logic        exp_src;

        idle_inputs();
        rst = 1;
        RD1_E = 64'h1234; RD2_E = 64'h55; RegWrite_E = 1; Rd_E = 5'd3;
        step();
        step();
        check_all_zero("reset");
        rst = 0;
        exp_alu_m = '0;

        for (int i = 0; i < 300; i++) begin
            RD1_E = rnd64(); RD2_E = rnd64(); Result_W = rnd64(); ImmExt_E = rnd64();
            PC_E = {$urandom, $urandom};
            ALUSrc_E = 1'($urandom); Word_E = 1'($urandom); Jalr_E = 1'($urandom);
            Branch_E = 1'($urandom); Jump_E = ($urandom_range(0, 3) == 0);
            ALUControl_E = 4'($urandom); Funct3_E = 3'($urandom);
            ForwardA_E = 2'($urandom); ForwardB_E = 2'($urandom);
            Rd_E = 5'($urandom); RegWrite_E = 1'($urandom); MemWrite_E = 1'($urandom);
            ResultSrc_E = 2'($urandom);
            a  = (ForwardA_E == 1) ? Result_W : (ForwardA_E == 2) ? exp_alu_m : RD1_E;
            fb = (ForwardB_E == 1) ? Result_W : (ForwardB_E == 2) ? exp_alu_m : RD2_E;
            b  = ALUSrc_E ? ImmExt_E : fb;
            exp_src = Jump_E || (Branch_E && taken_ref(a, fb, int'(Funct3_E)));
            exp_tgt = Jalr_E ? ((a + ImmExt_E) & ~64'h1) : (PC_E + ImmExt_E);
            #1;
            check("rnd_pcsrc", 64'(PCSrc_E), 64'(exp_src));
            check("rnd_target", PCTarget_E, exp_tgt);
            exp_alu_m = alu_ref(a, b, int'(ALUControl_E), Word_E);
            step();
            check("rnd_alu", ALUResult_M, exp_alu_m);
            check("rnd_wdata", WriteData_M, fb);
            check("rnd_pc4", PCPlus4_M, PC_E + 4);
            check("rnd_rd", 64'(Rd_M), 64'(Rd_E));
            check("rnd_regwrite", 64'(RegWrite_M), 64'(RegWrite_E));
            check("rnd_memwrite", 64'(MemWrite_M), 64'(MemWrite_E));
            check("rnd_resultsrc", 64'(ResultSrc_M), 64'(ResultSrc_E));
        end

        idle_inputs();
        run_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd0, 0, 64'h0);
        run_op("sub_wrap", 64'h0, 64'd1, 4'd1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("sh3add", 64'hFFFF_FFFF_0000_0003, 64'd10, 4'd12, 0, 64'hFFFF_FFF8_0000_0022);
        run_op("add_uw", 64'hFFFF_FFFF_0000_0003, 64'd10, 4'd13, 0, 64'd13);
        run_op("slli_uw", 64'hFFFF_FFFF_0000_0003, 64'd4, 4'd14, 0, 64'h30);
        run_op("addw", 64'h7FFF_FFFF, 64'd1, 4'd0, 1, 64'hFFFF_FFFF_8000_0000);
        run_op("sraw", 64'h8000_0000, 64'd4, 4'd9, 1, 64'hFFFF_FFFF_F800_0000);
        run_op("andw_ignored", 64'hF0F0_F0F0_F0F0_F0F0, 64'hFFFF_0000_FFFF_0000, 4'd2, 1,
               64'hF0F0_0000_F0F0_0000);

        run_op("fwd_setup", 64'd2, 64'd3, 4'd0, 0, 64'd5);
        RD1_E = 64'h0; ForwardA_E = 2'b10; RD2_E = 64'd5; ForwardB_E = 2'b00;
        Branch_E = 1; Funct3_E = 3'b000; PC_E = 64'h100; ImmExt_E = 64'h40;
        #1;
        check("beq_fwd_pcsrc", 64'(PCSrc_E), 64'd1);
        check("beq_fwd_target", PCTarget_E, 64'h140);
        Funct3_E = 3'b001;
        #1;
        check("bne_fwd_pcsrc", 64'(PCSrc_E), 64'd0);
        Funct3_E = 3'b010;
        RD2_E = 64'd7;
        #1;
        check("f3_010_never", 64'(PCSrc_E), 64'd0);

        idle_inputs();
        RD1_E = 64'h1001; ImmExt_E = 64'd2; Jump_E = 1; Jalr_E = 1; PC_E = 64'h2000;
        ALUSrc_E = 1;
        #1;
        check("jalr_target", PCTarget_E, 64'h1002);
        check("jalr_pcsrc", 64'(PCSrc_E), 64'd1);
        step();
        check("jalr_pc4", PCPlus4_M, 64'h2004);

        idle_inputs();
        RegWrite_E = 1; MemWrite_E = 1; Rd_E = 5'd7; ResultSrc_E = 2'd2;
        RD1_E = 64'd40; RD2_E = 64'd2; ALUControl_E = 4'd0;
        step();
        check("load_rd", 64'(Rd_M), 64'd7);
        check("load_rw", 64'(RegWrite_M), 64'd1);
        check("load_alu", ALUResult_M, 64'd42);
        StallM = 1; RegWrite_E = 0; MemWrite_E = 0; Rd_E = 5'd9; ResultSrc_E = 2'd1;
        RD1_E = 64'd1; PC_E = 64'h80;
        for (int c = 0; c < 2; c++) begin
            step();
            check("stall_rd", 64'(Rd_M), 64'd7);
            check("stall_rw", 64'(RegWrite_M), 64'd1);
            check("stall_mw", 64'(MemWrite_M), 64'd1);
            check("stall_rs", 64'(ResultSrc_M), 64'd2);
            check("stall_alu", ALUResult_M, 64'd42);
            check("stall_pc4", PCPlus4_M, 64'd4);
        end
        FlushM = 1; RegWrite_E = 1; MemWrite_E = 1; Rd_E = 5'd12;
        step();
        check("flush_rw", 64'(RegWrite_M), 64'd0);
        check("flush_mw", 64'(MemWrite_M), 64'd0);
        check("flush_rd", 64'(Rd_M), 64'd0);
        check("flush_rs", 64'(ResultSrc_M), 64'd0);
        FlushM = 0; StallM = 0;
        step();
        check("reload_rd", 64'(Rd_M), 64'd12);
        rst = 1; StallM = 1;
        step();
        check_all_zero("rst_stall");
        rst = 0;
        step();
        check("still_stalled_rd", 64'(Rd_M), 64'd0);
        StallM = 0;
        step();
        check("resume_rd", 64'(Rd_M), 64'd12);
        check("resume_rw", 64'(RegWrite_M), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
